// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter with a registered one-hot grant, hold-quantum preemption and a no-bubble hand-off.
// Latency: 1 cycle from req to gnt; the hand-off to a waiting requester happens on the releasing edge.
// Backpressure: none; the owner keeps the resource until done, until its req drops, or until its quantum expires.
//
// Ports:
//   clk       - clock, all state updates on posedge
//   rst_n     - asynchronous active-low reset
//   req[N]    - request vector, bit i = requester i wants the resource
//   done      - the owner releases the resource (ignored while idle)
//   gnt[N]    - registered grant, all-zero or one-hot
//   gnt_valid - |gnt
//   gnt_id    - index of the granted bit; keeps the last owner while idle
//   hold_cnt  - cycles the current owner has held, minus 1 (saturates)
//   preempt   - one-cycle pulse aligned with a grant produced by quantum expiry
module rr_onehot_arbiter #(
  parameter int N        = 5,
  parameter int MAX_HOLD = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N-1:0]                req,
  input  logic                        done,
  output logic [N-1:0]                gnt,
  output logic                        gnt_valid,
  output logic [$clog2(N)-1:0]        gnt_id,
  output logic [$clog2(MAX_HOLD)-1:0] hold_cnt,
  output logic                        preempt
);

  localparam int IW = $clog2(N);
  localparam int HW = $clog2(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [N-1:0]  r_gnt, w_gnt_nxt;
  logic [IW-1:0] r_gnt_id, w_gnt_id_nxt;
  logic [HW-1:0] r_hold, w_hold_nxt;
  logic          r_preempt, w_preempt_nxt;
  logic [IW-1:0] r_ptr, w_ptr_nxt;

  logic [IW-1:0] w_sel_id;
  logic [N-1:0]  w_sel_oh;
  logic          w_found;
  logic          w_release;
  logic          w_others;

  // Modulo-N add for indices, keeps the scan inside 0..N-1.
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] a, input int b);
    int s;
    s = int'(a) + b;
    if (s >= N) s = s - N;
    return s[IW-1:0];
  endfunction

  // First set request scanning from ptr upward with wrap. Because ptr is
  // always owner+1 after a grant, the current owner is naturally the last
  // candidate, which gives the "others first" rule on hand-off.
  always_comb begin
    w_found  = 1'b0;
    w_sel_id = r_ptr;
    for (int i = 0; i < N; i++) begin
      if (!w_found && req[wrap_add(r_ptr, i)]) begin
        w_found  = 1'b1;
        w_sel_id = wrap_add(r_ptr, i);
      end
    end
  end

  assign w_sel_oh  = {{(N-1){1'b0}}, 1'b1} << w_sel_id;
  // done and owner req drop in the same cycle fold into one release.
  assign w_release = done || ((req & r_gnt) == '0);
  assign w_others  = (req & ~r_gnt) != '0;

  always_comb begin
    w_state_nxt   = r_state;
    w_gnt_nxt     = r_gnt;
    w_gnt_id_nxt  = r_gnt_id;
    w_hold_nxt    = r_hold;
    w_preempt_nxt = 1'b0;
    w_ptr_nxt     = r_ptr;

    unique case (r_state)
      IDLE: begin
        if (req != '0) begin
          w_state_nxt  = BUSY;
          w_gnt_nxt    = w_sel_oh;
          w_gnt_id_nxt = w_sel_id;
          w_hold_nxt   = '0;
          w_ptr_nxt    = wrap_add(w_sel_id, 1);
        end
      end
      BUSY: begin
        if (w_release || (r_hold == HOLD_LAST)) begin
          if (w_others) begin
            w_gnt_nxt     = w_sel_oh;
            w_gnt_id_nxt  = w_sel_id;
            w_hold_nxt    = '0;
            w_ptr_nxt     = wrap_add(w_sel_id, 1);
            w_preempt_nxt = !w_release;
          end else if (w_release) begin
            w_state_nxt = IDLE;
            w_gnt_nxt   = '0;
            w_hold_nxt  = '0;
          end
          // else: quantum expired but nobody waits; hold_cnt stays saturated.
        end else begin
          w_hold_nxt = r_hold + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_gnt     <= '0;
      r_gnt_id  <= '0;
      r_hold    <= '0;
      r_preempt <= 1'b0;
      r_ptr     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_gnt     <= w_gnt_nxt;
      r_gnt_id  <= w_gnt_id_nxt;
      r_hold    <= w_hold_nxt;
      r_preempt <= w_preempt_nxt;
      r_ptr     <= w_ptr_nxt;
    end
  end

  assign gnt       = r_gnt;
  assign gnt_valid = |r_gnt;
  assign gnt_id    = r_gnt_id;
  assign hold_cnt  = r_hold;
  assign preempt   = r_preempt;

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Table-driven bench for rr_onehot_arbiter (N=5, MAX_HOLD=4) with an
// expected-value queue and a concurrent grant-invariant monitor.
module tb_rr_onehot_arbiter;

  localparam int N  = 5;
  localparam int MH = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req;
  logic         done;
  logic [N-1:0] gnt;
  logic         gnt_valid;
  logic [2:0]   gnt_id;
  logic [1:0]   hold_cnt;
  logic         preempt;

  int tests = 0;
  int fails = 0;

  rr_onehot_arbiter #(.N(N), .MAX_HOLD(MH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .hold_cnt  (hold_cnt),
    .preempt   (preempt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] req;
    logic         done;
    logic [N-1:0] gnt;
    logic [2:0]   id;
    logic [1:0]   hold;
    logic         pre;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  function automatic vec_t mk(input logic [N-1:0] r, input logic d, input logic [N-1:0] g,
                              input logic [2:0] id, input logic [1:0] h, input logic p);
    vec_t v;
    v.req = r; v.done = d; v.gnt = g; v.id = id; v.hold = h; v.pre = p;
    return v;
  endfunction

  task automatic cmp(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag, input vec_t e);
    cmp({tag, " gnt"}, int'(gnt), int'(e.gnt));
    cmp({tag, " gnt_valid"}, int'(gnt_valid), int'(e.gnt != '0));
    cmp({tag, " gnt_id"}, int'(gnt_id), int'(e.id));
    cmp({tag, " preempt"}, int'(preempt), int'(e.pre));
    if (e.gnt != '0) cmp({tag, " hold_cnt"}, int'(hold_cnt), int'(e.hold));
  endtask

  // Drive one vector on the falling edge, queue its expectation, and
  // compare against the outputs just after the next rising edge.
  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    @(negedge clk);
    req  = v.req;
    done = v.done;
    sb.push_back(v);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      cmp($sformatf("row%0d queue", idx), 0, 1);
    end else begin
      e = sb.pop_front();
      check_outputs($sformatf("row%0d", idx), e);
    end
  endtask

  // Grant invariants checked continuously once reset has been seen.
  logic mon_en = 1'b0;
  always @(negedge clk) begin
    if (mon_en) begin
      tests++;
      assert ($onehot0(gnt) && (gnt_valid == (|gnt)) && (!gnt_valid || gnt[gnt_id]))
      else begin
        fails++;
        $display("FAIL invariant: gnt=%b gnt_valid=%b gnt_id=%0d", gnt, gnt_valid, gnt_id);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t z;
    rst_n = 1'b1;
    req   = '0;
    done  = 1'b0;

    // Round robin with done every cycle, no idle gaps.
    tbl.push_back(mk(5'b11111, 1, 5'b00001, 0, 0, 0));
    tbl.push_back(mk(5'b11111, 1, 5'b00010, 1, 0, 0));
    tbl.push_back(mk(5'b11111, 1, 5'b00100, 2, 0, 0));
    tbl.push_back(mk(5'b11111, 1, 5'b01000, 3, 0, 0));
    tbl.push_back(mk(5'b11111, 1, 5'b10000, 4, 0, 0));
    tbl.push_back(mk(5'b11111, 1, 5'b00001, 0, 0, 0));
    // Hand-off: owner 1 drops req while 3 waits, then everyone goes idle.
    tbl.push_back(mk(5'b01010, 1, 5'b00010, 1, 0, 0));
    tbl.push_back(mk(5'b01000, 0, 5'b01000, 3, 0, 0));
    tbl.push_back(mk(5'b00000, 0, 5'b00000, 3, 0, 0));
    // Preemption after MAX_HOLD cycles, back and forth.
    tbl.push_back(mk(5'b00011, 0, 5'b00001, 0, 0, 0));
    tbl.push_back(mk(5'b00011, 0, 5'b00001, 0, 1, 0));
    tbl.push_back(mk(5'b00011, 0, 5'b00001, 0, 2, 0));
    tbl.push_back(mk(5'b00011, 0, 5'b00001, 0, 3, 0));
    tbl.push_back(mk(5'b00011, 0, 5'b00010, 1, 0, 1));
    tbl.push_back(mk(5'b00011, 0, 5'b00010, 1, 1, 0));
    tbl.push_back(mk(5'b00011, 0, 5'b00010, 1, 2, 0));
    tbl.push_back(mk(5'b00011, 0, 5'b00010, 1, 3, 0));
    tbl.push_back(mk(5'b00011, 0, 5'b00001, 0, 0, 1));
    // Solo owner for 10 cycles: hold saturates, no preempt.
    tbl.push_back(mk(5'b01000, 0, 5'b01000, 3, 0, 0));
    tbl.push_back(mk(5'b01000, 0, 5'b01000, 3, 1, 0));
    tbl.push_back(mk(5'b01000, 0, 5'b01000, 3, 2, 0));
    for (int k = 0; k < 7; k++) tbl.push_back(mk(5'b01000, 0, 5'b01000, 3, 3, 0));
    // done in IDLE is ignored; done plus req drop is one release.
    tbl.push_back(mk(5'b00000, 0, 5'b00000, 3, 0, 0));
    tbl.push_back(mk(5'b00000, 1, 5'b00000, 3, 0, 0));
    tbl.push_back(mk(5'b00100, 1, 5'b00100, 2, 0, 0));
    tbl.push_back(mk(5'b00000, 1, 5'b00000, 2, 0, 0));
    tbl.push_back(mk(5'b10000, 0, 5'b10000, 4, 0, 0));

    // Reset values, observed before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    z = mk(5'b00000, 0, 5'b00000, 0, 0, 0);
    check_outputs("reset", z);
    cmp("reset hold_cnt", int'(hold_cnt), 0);
    mon_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single request right after reset.
    apply(mk(5'b00100, 0, 5'b00100, 2, 0, 0), 100);
    apply(mk(5'b00000, 0, 5'b00000, 2, 0, 0), 101);

    // Second reset so the round-robin table starts from ptr=0.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // Mid-BUSY asynchronous reset between edges with gnt=10000.
    #2 rst_n = 1'b0;
    #1;
    check_outputs("midrst", z);
    cmp("midrst hold_cnt", int'(hold_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    req   = '0;
    done  = 1'b0;
    apply(mk(5'b11000, 0, 5'b01000, 3, 0, 0), 200);
    cmp("scoreboard empty", sb.size(), 0);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
